uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_rx_fifo.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// ============================================================================
//  Module   : uart_rx_fifo_pkg
//  Purpose  : Register map, STATUS bit positions and receiver state encodings
//             shared by the UART receive path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_fifo_pkg;

  localparam logic [31:0] REG_DATA_OFF   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS_OFF = 32'h0000_0004;
  // Only address bit 2 distinguishes the two registers.
  localparam logic [31:0] REG_SEL_MASK   = 32'h0000_0004;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVR       = 2;
  localparam int STAT_FERR      = 3;
  localparam int STAT_PERR      = 4;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4,
    S_DATA2 = 3'd5
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word fall-through FIFO; a push into a full
//             FIFO is accepted only when a pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q;
  logic [c_aw-1:0]  rd_ptr_q;
  logic [c_aw:0]    count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (c_aw+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Memory-mapped UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN
//             is defined) feeding a receive FIFO read through DATA/STATUS.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        rx
);

  localparam int c_clks_per_bit = CLK_HZ / BAUD;
  localparam int c_cnt_w        = $clog2(c_clks_per_bit);
  localparam int c_count_w      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_clks_per_bit / 2 - 1);

  logic                 rx_meta_q;
  logic                 rx_sync_q;
  rx_state_e            state_q;
  logic [c_cnt_w-1:0]   cnt_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic                 push_q;
  logic                 ferr_set_q;
  logic                 mem_ready_q;
  logic [31:0]          rdata_q;
  logic [31:0]          rdata_d;
  logic                 ovr_q;
  logic                 ovr_d;
  logic                 ferr_q;
  logic                 ferr_d;
  logic                 w_perr;

  logic [7:0]           w_dout;
  logic                 w_empty;
  logic                 w_full;
  logic [c_count_w-1:0] w_count;
  logic [31:0]          w_reg_off;
  logic                 w_sel_data;
  logic                 w_sel_status;
  logic                 w_accept;
  logic                 w_write;
  logic                 w_pop;
  logic                 w_clr_en;
  logic                 w_set_ovr;
  logic [31:0]          w_status;
  logic                 w_unused_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic perr_set_q;
  logic perr_q;
  logic perr_d;
`endif

  // Receiver FSM: every sample is taken when the bit counter reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_set_q <= 1'b0;
`endif
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            cnt_q   <= c_cnt_half;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (!rx_sync_q) begin
              bit_idx_q <= '0;
              cnt_q     <= c_cnt_full;
              state_q   <= S_DATA;
`ifdef UART_RX_PARITY_EN
              par_bad_q <= 1'b0;
`endif
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            cnt_q   <= c_cnt_full;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_DATA2;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_DATA2: begin
          if (cnt_q == '0) begin
            par_bad_q  <= ^{shift_q, rx_sync_q};
            perr_set_q <= ^{shift_q, rx_sync_q};
            cnt_q      <= c_cnt_full;
            state_q    <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == '0) begin
            if (rx_sync_q) begin
`ifdef UART_RX_PARITY_EN
              push_q <= !par_bad_q;
`else
              push_q <= 1'b1;
`endif
              state_q <= S_IDLE;
            end else begin
              ferr_set_q <= 1'b1;
              state_q    <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_sync_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .din   (shift_q),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign w_reg_off    = mem_addr & REG_SEL_MASK;
  assign w_sel_data   = (w_reg_off == REG_DATA_OFF);
  assign w_sel_status = (w_reg_off == REG_STATUS_OFF);
  assign w_accept     = enable && mem_valid && !mem_ready_q;
  assign w_write      = |mem_wstrb;
  assign w_pop        = w_accept && w_sel_data && !w_write && !w_empty;
  assign w_clr_en     = w_accept && w_sel_status && mem_wstrb[0];
  // A pop in the same cycle makes room, so only an unrelieved full is an overrun.
  assign w_set_ovr    = push_q && w_full && !w_pop;

  assign ovr_d  = w_set_ovr  | (ovr_q  & ~(w_clr_en & mem_wdata[STAT_OVR]));
  assign ferr_d = ferr_set_q | (ferr_q & ~(w_clr_en & mem_wdata[STAT_FERR]));

`ifdef UART_RX_PARITY_EN
  assign perr_d = perr_set_q | (perr_q & ~(w_clr_en & mem_wdata[STAT_PERR]));
  assign w_perr = perr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign w_unused_ok = &{1'b0, mem_instr, mem_wdata[31:5], mem_wdata[1:0]};
`else
  assign w_perr      = 1'b0;
  assign w_unused_ok = &{1'b0, mem_instr, mem_wdata[31:STAT_PERR], mem_wdata[1:0]};
`endif

  always_comb begin
    w_status                       = '0;
    w_status[STAT_NOT_EMPTY]       = !w_empty;
    w_status[STAT_FULL]            = w_full;
    w_status[STAT_OVR]             = ovr_q;
    w_status[STAT_FERR]            = ferr_q;
    w_status[STAT_PERR]            = w_perr;
    w_status[STAT_COUNT_LSB +: 8]  = 8'(w_count);
  end

  always_comb begin
    rdata_d = '0;
    if (w_accept && !w_write) begin
      if (w_sel_data) begin
        rdata_d = {24'b0, (w_empty ? 8'h00 : w_dout)};
      end else begin
        rdata_d = w_status;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready_q <= 1'b0;
      rdata_q     <= '0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      mem_ready_q <= w_accept;
      rdata_q     <= rdata_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo against a queue-based model
//             of the receive FIFO and its sticky flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int c_clk_hz = 1000000;
  localparam int c_baud   = 100000;
  localparam int c_cpb    = 10;
  localparam int c_depth  = 16;
`ifdef UART_RX_PARITY_EN
  localparam int c_push_edge = 108;
`else
  localparam int c_push_edge = 98;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rx;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q[$];
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_perr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ     (c_clk_hz),
    .BAUD       (c_baud),
    .FIFO_DEPTH (c_depth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rx        (rx)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (m_q.size() != 0);
    s[1]    = (m_q.size() == c_depth);
    s[2]    = m_ovr;
    s[3]    = m_ferr;
    s[4]    = m_perr;
    s[15:8] = 8'(m_q.size());
    return s;
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic par_ok);
    if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
      m_perr = 1'b1;
`endif
    end
    if (!stop) begin
      m_ferr = 1'b1;
    end else if (par_ok) begin
      if (m_q.size() < c_depth) m_q.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic bit_time();
    repeat (c_cpb) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is always 1 time unit after a rising edge; rx leaves at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ ~par_ok;
    bit_time();
`endif
    rx = stop;
    bit_time();
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1);
    model_frame(b, 1'b1, 1'b1);
  endtask

  task automatic bus(input logic sel_status, input logic [3:0] wstrb,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    logic [31:0] a;
    logic        ok;
    a         = $urandom;
    a[2]      = sel_status;
    mem_addr  = a;
    mem_wstrb = wstrb;
    mem_wdata = wdata;
    enable    = 1'b1;
    mem_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    enable    = 1'b0;
    mem_wstrb = 4'h0;
    check_value("bus_ack", {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
    check_value("ready_one_cycle", {31'b0, mem_ready}, 32'd0);
    check_value("rdata_idle_zero", mem_rdata, 32'd0);
  endtask

  task automatic read_data_chk(input string tag);
    logic [31:0] r;
    logic [31:0] exp;
    bus(1'b0, 4'h0, 32'h0, r);
    exp = (m_q.size() != 0) ? {24'b0, m_q.pop_front()} : 32'h0;
    check_value(tag, r, exp);
  endtask

  task automatic read_status_chk(input string tag);
    logic [31:0] r;
    bus(1'b1, 4'h0, 32'h0, r);
    check_value(tag, r, model_status());
  endtask

  task automatic write_status(input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] r;
    bus(1'b1, wstrb, wdata, r);
    if (wstrb[0]) begin
      if (wdata[2]) m_ovr  = 1'b0;
      if (wdata[3]) m_ferr = 1'b0;
      if (wdata[4]) m_perr = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  exp_b;
    int          n;
    int          k;

    reset     = 1'b1;
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wstrb = 4'h0;
    mem_wdata = '0;
    rx        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_ready", {31'b0, mem_ready}, 32'd0);
    check_value("rst_rdata", mem_rdata, 32'd0);
    reset = 1'b0;
    idle(2);
    read_status_chk("rst_status");
    read_data_chk("empty_read");

    send_good(8'hA5);
    read_status_chk("a5_status");
    read_data_chk("a5_data");
    read_status_chk("a5_status_after");

    bus(1'b0, 4'hF, 32'h0000_00FF, r);
    read_status_chk("data_write_noeffect");

    for (int i = 0; i < 17; i++) send_good(8'(i));
    read_status_chk("overrun_status");
    for (int i = 0; i < 16; i++) read_data_chk("overrun_data");
    write_status(32'h4, 4'h1);
    read_status_chk("ovr_cleared");

    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    read_status_chk("glitch_status");

    send_frame(8'h3C, 1'b0, 1'b1);
    model_frame(8'h3C, 1'b0, 1'b1);
    idle(50);
    read_status_chk("break_status");
    rx = 1'b1;
    idle(5);
    send_good(8'h55);
    read_data_chk("after_break_data");
    write_status(32'h8, 4'h1);
    read_status_chk("ferr_cleared");

    for (int i = 0; i < c_depth; i++) send_good(8'($urandom));
    read_status_chk("prefill_status");
    b     = 8'($urandom);
    exp_b = m_q.pop_front();
    fork
      send_frame(b, 1'b1, 1'b1);
      begin
        repeat (c_push_edge) @(posedge clk);
        #1;
        bus(1'b0, 4'h0, 32'h0, r);
      end
    join
    check_value("pop_push_data", r, {24'b0, exp_b});
    model_frame(b, 1'b1, 1'b1);
    read_status_chk("pop_push_status");
    for (int i = 0; i < c_depth; i++) read_data_chk("pop_push_drain");
    read_status_chk("pop_push_empty");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0);
    read_status_chk("parity_bad_status");
    send_good(8'h07);
    read_status_chk("parity_good_status");
    read_data_chk("parity_good_data");
    write_status(32'h10, 4'h1);
    read_status_chk("perr_cleared");
`endif

    for (int rnd = 0; rnd < 3; rnd++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        send_good(8'($urandom));
        idle($urandom_range(0, 3));
      end
      read_status_chk("rand_status_fill");
      k = $urandom_range(0, n + 1);
      for (int i = 0; i < k; i++) read_data_chk("rand_data");
      read_status_chk("rand_status_read");
      write_status($urandom, 4'($urandom));
      read_status_chk("rand_status_clear");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
